mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer for a single shared memory port serving the two memory requesters of the five-stage pipeline: instruction fetch (IF) and data access (MEM). It sits between the datapath's fetch and memory-access logic and a unified single-port memory. It allows one outstanding transaction at a time and routes each response back to its owner. Data accesses have priority, and a starvation guard guarantees fetch forward progress.

## Interface
Parameters:
- ADDR_W, 9, memory word-address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive lost IF arbitrations after which IF wins once (1..15)
- CNT_W, 16, width of the conflict counter

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until granted
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted by memory this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request, held until granted
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  data response (read data or write ack) valid
- dm_rdata  out  DATA_W  data read data
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  write data to memory
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  memory response valid (reads and writes)
- mem_rdata  in  DATA_W  memory read data
- conflict_cnt  out  CNT_W  cycles in which both requesters asked in IDLE; saturating

## Operation
- FSM states: IDLE, WAIT_IF, WAIT_DM. Reset value is IDLE.
- IDLE:
  - mem_req = if_req | dm_req.
  - Winner selection: DM, unless starve_cnt == STARVE_MAX, in which case IF. With a single requester, that requester wins.
  - mem_we, mem_addr and mem_wdata carry the winner's fields. For an IF winner, mem_we = 0 and mem_wdata = 0.
  - Grant: winner_gnt = winner selected & mem_ready. The loser's gnt is 0.
  - On grant, the FSM moves to WAIT_IF or WAIT_DM.
- WAIT_x:
  - mem_req = 0 and both gnts are 0.
  - x_rvalid = mem_rvalid and x_rdata = mem_rdata; the other requester's rvalid is 0.
  - On mem_rvalid, the FSM returns to IDLE.
- Outside WAIT_IF, if_rvalid = 0. Outside WAIT_DM, dm_rvalid = 0.
- A mem_rvalid received in IDLE is ignored.
- Output rdata when the matching rvalid is 0 = 0.
- starve_cnt is internal and 4 bits wide. Each IDLE cycle it updates by the first matching rule:
  - if_gnt = 1 or if_req = 0: clear to 0.
  - dm_gnt = 1 while if_req = 1: increment, saturating at STARVE_MAX.
  - Otherwise: hold.
  - In WAIT states it holds.
- conflict_cnt increments in every IDLE cycle with if_req & dm_req, whether or not mem_ready is set. It saturates at all-ones.
- Reset (synchronous): state = IDLE, starve_cnt = 0, conflict_cnt = 0.
  - While reset is high, all outputs are forced to 0: gnts, rvalids, rdatas, and all mem_* outputs.
  - Reset mid-transaction abandons the outstanding response. A late mem_rvalid arrives in IDLE and is ignored.
- Simultaneous events: in the IDLE cycle after a response, a new grant may issue. The same-cycle response and new grant are never both seen, because the response is consumed in WAIT_x.

## Timing
- gnt, rvalid, rdata and all mem_* outputs are combinational from state and inputs. There is no added latency.
- With mem_ready = 1 and mem_rvalid one cycle after acceptance:
  - grant at cycle N, response at N+1, next grant at N+2.
  - Peak throughput is one transaction per 2 cycles.
- A requester must keep its req and fields stable until its gnt is seen. A req deasserted before gnt is legal and simply cancels the request.
- Memory stall (mem_ready = 0) holds the FSM in IDLE. Winner selection is re-evaluated every cycle.
- Response latency is unbounded. The arbiter waits in WAIT_x indefinitely.

## Test plan
- Single IF read:
  - Stimulus: if_req = 1, if_addr = 0x004, mem_ready = 1, mem_rvalid at +1 with mem_rdata = 0x00500093.
  - Required: if_gnt at cycle 0, if_rvalid = 1 with if_rdata = 0x00500093 at cycle 1, dm_rvalid = 0, state back in IDLE at cycle 2.
- Conflict:
  - Stimulus: if_req and dm_req (write, addr 0x010, data 0xDEADBEEF) both asserted.
  - Required: dm_gnt first with mem_we = 1, mem_wdata = 0xDEADBEEF; if_gnt at cycle 2; conflict_cnt = 1.
- Starvation guard (STARVE_MAX = 4):
  - Stimulus: dm_req and if_req held continuously.
  - Required: 4 DM grants, then the 5th grant goes to IF; starve_cnt then clears and DM wins the next grant.
- Memory stall:
  - Stimulus: mem_ready = 0 for 3 cycles with dm_req = 1.
  - Required: mem_req = 1 with no gnt for those cycles; dm_gnt in the first cycle mem_ready = 1; conflict_cnt unchanged.
- Reset mid-transaction:
  - Stimulus: assert reset in WAIT_DM, then mem_rvalid = 1 one cycle after reset deasserts.
  - Required: all outputs 0 during reset; dm_rvalid stays 0; a new if_req is granted immediately.
- Counter saturation:
  - Stimulus: CNT_W = 4, 20 conflict cycles.
  - Required: conflict_cnt = 15.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding arbiter sharing a single memory port between fetch and data access
//
// Purpose: grants a unified single-port memory to either the instruction-fetch
// (if_*) or data-access (dm_*) requester, tracks the one outstanding
// transaction and routes its response back to the owner. Data access wins
// conflicts; a starvation guard hands fetch one grant after STARVE_MAX
// consecutive lost arbitrations.
//
// Ports:
//   clock, reset                 - rising-edge clock, synchronous active-high reset
//   if_req/if_addr               - fetch request; if_gnt/if_rvalid/if_rdata back
//   dm_req/dm_we/dm_addr/dm_wdata- data request; dm_gnt/dm_rvalid/dm_rdata back
//   mem_req/mem_we/mem_addr/mem_wdata - request to memory, mem_ready accepts it
//   mem_rvalid/mem_rdata         - memory response (reads and write acks)
//   conflict_cnt                 - saturating count of IDLE cycles with both requesting

module mem_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] starve_cnt;

    logic idle;
    logic sel_if;
    logic sel_dm;
    logic take_if;
    logic take_dm;

    // Fetch wins only when data is absent or the starvation guard has tripped.
    assign idle    = (state == IDLE);
    assign sel_if  = if_req & (~dm_req | (starve_cnt == 4'(STARVE_MAX)));
    assign sel_dm  = dm_req & ~sel_if;
    assign take_if = idle & sel_if & mem_ready;
    assign take_dm = idle & sel_dm & mem_ready;

    // State register plus the two counters that only move in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= 4'd0;
            conflict_cnt <= '0;
        end else begin
            state <= state_next;
            if (idle) begin
                if (take_if || !if_req) begin
                    starve_cnt <= 4'd0;
                end else if (take_dm && starve_cnt != 4'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
                if (if_req && dm_req && conflict_cnt != {CNT_W{1'b1}}) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
        end
    end

    // Next-state logic; a response seen in IDLE (e.g. after reset) is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take_if) begin
                    state_next = WAIT_IF;
                end else if (take_dm) begin
                    state_next = WAIT_DM;
                end
            end
            WAIT_IF, WAIT_DM: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are combinational from state and inputs; reset forces all to 0.
    always_comb begin
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    mem_req = if_req | dm_req;
                    if (sel_if) begin
                        mem_addr = if_addr;
                        if_gnt   = mem_ready;
                    end else if (sel_dm) begin
                        mem_we    = dm_we;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        dm_gnt    = mem_ready;
                    end
                end
                WAIT_IF: begin
                    if_rvalid = mem_rvalid;
                    if_rdata  = mem_rvalid ? mem_rdata : '0;
                end
                WAIT_DM: begin
                    dm_rvalid = mem_rvalid;
                    dm_rdata  = mem_rvalid ? mem_rdata : '0;
                end
                default: ;
            endcase
        end
    end

endmodule
